dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequenced two-requester arbiter for the single-port data memory.
- Requester 1 is the pipeline MEM stage. Requester 2 is a debug/program-loader port that writes or inspects data memory while the core runs.
- Sits between the EX_MEM outputs and Data_Memory. Raises core_stall whenever the MEM-stage access is not granted in the current cycle; the stall feeds the existing PC_Write/IF_ID_Write/pipeline-hold logic.

Parameters:
- MAX_WAIT, 4: consecutive contested cycles a pending dbg request may lose before it is forced through.
- MAX_BURST, 8: maximum consecutive dbg-locked grants while core_req is pending before the core is given one cycle.
- CNT_W, 4: width of the internal wait/burst counters; must hold max(MAX_WAIT, MAX_BURST).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- core_req  in  1  MEM-stage access request (MemRead_MEM | MemWrite_MEM).
- core_we  in  1  1 = store (MemWrite_MEM).
- core_addr  in  64  Result_MEM.
- core_wdata  in  64  Read_Data_2_MEM.
- core_funct3  in  3  access size/sign.
- core_rdata  out  64  load data, valid in the grant cycle.
- core_stall  out  1  MEM access not granted this cycle.
- dbg_req  in  1  debug access request.
- dbg_we  in  1  1 = write.
- dbg_lock  in  1  keep ownership for a burst.
- dbg_addr  in  64  debug address.
- dbg_wdata  in  64  debug write data.
- dbg_gnt  out  1  debug access performed this cycle.
- dbg_rvalid  out  1  registered read-data valid.
- dbg_rdata  out  64  registered read data.
- mem_addr  out  64  to Data_Memory.
- mem_wdata  out  64  to Data_Memory.
- mem_read  out  1  to Data_Memory.
- mem_write  out  1  to Data_Memory.
- mem_funct3  out  3  to Data_Memory; driven as 3'b011 (doubleword) for dbg.
- mem_rdata  in  64  combinational read data from Data_Memory.
- contention_cnt  out  32  cycles in which both requesters were active.

Behaviour:
- Memory model: combinational read, write committed at the clk edge of the grant cycle.
- State: owner in {CORE, DBG_BURST}; wait_cnt; burst_cnt.
- Grant (combinational, from state and current requests), evaluated in priority order:
  1. reset high: no grant; mem_read = 0, mem_write = 0, core_stall = 0, dbg_gnt = 0.
  2. owner == DBG_BURST and dbg_req and dbg_lock: grant dbg, unless core_req and burst_cnt == MAX_BURST, in which case grant core.
  3. Only one requester active: grant it.
  4. Both active: grant dbg if wait_cnt == MAX_WAIT, else grant core.
  5. Neither active: idle; mem_read = 0, mem_write = 0.
- Muxing: the granted side drives mem_addr, mem_wdata and mem_funct3. mem_read = granted & ~we; mem_write = granted & we.
- core_rdata = mem_rdata when the core is granted, else 0.
- core_stall = core_req & ~core_grant. A stalled core holds its request and operands until granted.
- dbg_gnt = dbg_grant. The dbg requester holds its inputs until dbg_gnt.
- Registered updates (each rising edge, reset has priority):
  - reset: owner = CORE, wait_cnt = 0, burst_cnt = 0, dbg_rvalid = 0, dbg_rdata = 0, contention_cnt = 0.
  - wait_cnt: 0 if dbg_gnt or ~dbg_req; else saturating increment up to MAX_WAIT.
  - owner: DBG_BURST if dbg_gnt & dbg_lock; CORE if dbg_req & dbg_lock & ~dbg_gnt (core forced through) is false and the lock drops; CORE otherwise.
  - Forced-core cycle: owner stays DBG_BURST, burst_cnt = 0.
  - burst_cnt: increments on each dbg_gnt with owner == DBG_BURST and core_req; saturates at MAX_BURST; 0 whenever owner becomes CORE.
  - dbg_rvalid: <= dbg_gnt & ~dbg_we.
  - dbg_rdata: <= mem_rdata when dbg_gnt & ~dbg_we; otherwise holds.
  - contention_cnt: increments when core_req & dbg_req; wraps at 2^32.
- Latency:
  - Core access: 0 extra cycles when uncontested.
  - Dbg write: committed in the dbg_gnt cycle.
  - Dbg read: data appears 1 cycle after dbg_gnt.
- Boundary conditions:
  - Core stall bound under contention without lock: MAX_WAIT+1 cycles between successive dbg grants is the worst case for dbg. The core loses at most 1 cycle per dbg grant.
  - With lock: the core loses at most MAX_BURST consecutive cycles.
  - dbg_lock dropped mid-burst: owner returns to CORE the next cycle.
  - Reset mid-burst: no write is issued in the reset cycle; dbg_rvalid is cleared.

Test Plan:
- Core only: core load addr 0x10, mem_rdata 0xDEAD -> core_rdata = 0xDEAD in the same cycle, core_stall = 0, mem_read = 1, contention_cnt stays 0.
- Dbg read only: dbg_req, addr 0x20 -> dbg_gnt = 1, mem_funct3 = 3'b011; next cycle dbg_rvalid = 1 with dbg_rdata = mem_rdata sampled at grant.
- Continuous contention, no lock, MAX_WAIT = 4: core wins 4 cycles, dbg wins the 5th (core_stall = 1 only that cycle); pattern repeats; contention_cnt = 10 after 10 cycles.
- Locked dbg burst of 12 writes with core_req held, MAX_BURST = 8: 8 dbg_gnt, then 1 core grant, then the remaining 4 dbg grants. core_stall is never high for more than 8 consecutive cycles.
- Reset asserted during a locked burst with dbg_we = 1: mem_write = 0 that cycle; afterwards owner = CORE, dbg_rvalid = 0, contention_cnt = 0.
- Simultaneous first request, both sides, wait_cnt = 0: core granted, dbg_gnt = 0, wait_cnt = 1 next cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: pipeline MEM stage vs. debug/loader port.
// The core normally wins; dbg is forced through after MAX_WAIT lost cycles, or owns the port during a locked burst.
module dmem_arbiter #(
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [63:0] core_addr,
    input  logic [63:0] core_wdata,
    input  logic [2:0]  core_funct3,
    output logic [63:0] core_rdata,
    output logic        core_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic        dbg_lock,
    input  logic [63:0] dbg_addr,
    input  logic [63:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [63:0] dbg_rdata,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    input  logic [63:0] mem_rdata,
    output logic [31:0] contention_cnt
);
    typedef enum logic {CORE = 1'b0, DBG_BURST = 1'b1} owner_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  funct3;
        logic        we;
    } mem_req_t;

    localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    owner_t           owner, owner_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_nxt;
    logic             core_grant, dbg_grant, forced_core;
    mem_req_t         core_r, dbg_r, sel_r;

    assign core_r = '{addr: core_addr, wdata: core_wdata, funct3: core_funct3, we: core_we};
    assign dbg_r  = '{addr: dbg_addr, wdata: dbg_wdata, funct3: 3'b011, we: dbg_we};

    always_comb begin
        core_grant = 1'b0;
        dbg_grant  = 1'b0;
        if (!reset) begin
            if (owner == DBG_BURST && dbg_req && dbg_lock) begin
                if (core_req && burst_cnt == BURST_MAX) core_grant = 1'b1;
                else                                    dbg_grant  = 1'b1;
            end else if (core_req && dbg_req) begin
                if (wait_cnt == WAIT_MAX) dbg_grant  = 1'b1;
                else                      core_grant = 1'b1;
            end else begin
                core_grant = core_req;
                dbg_grant  = dbg_req;
            end
        end
    end

    assign forced_core = (owner == DBG_BURST) && dbg_req && dbg_lock && core_grant;

    // The grant that opens a burst counts toward burst_cnt, so the core never
    // loses more than MAX_BURST consecutive cycles to a locked burst.
    always_comb begin
        owner_nxt = CORE;
        burst_nxt = '0;
        if (dbg_grant || !dbg_req)  wait_nxt = '0;
        else if (wait_cnt == WAIT_MAX) wait_nxt = wait_cnt;
        else                        wait_nxt = wait_cnt + 1'b1;
        if (forced_core) begin
            owner_nxt = DBG_BURST;
        end else if (dbg_grant && dbg_lock) begin
            owner_nxt = DBG_BURST;
            burst_nxt = burst_cnt;
            if (core_req && burst_cnt != BURST_MAX) burst_nxt = burst_cnt + 1'b1;
        end
    end

    assign sel_r      = dbg_grant ? dbg_r : core_r;
    assign mem_addr   = sel_r.addr;
    assign mem_wdata  = sel_r.wdata;
    assign mem_funct3 = sel_r.funct3;
    assign mem_read   = (core_grant & ~core_we) | (dbg_grant & ~dbg_we);
    assign mem_write  = (core_grant & core_we) | (dbg_grant & dbg_we);
    assign core_rdata = core_grant ? mem_rdata : 64'd0;
    assign core_stall = core_req & ~core_grant & ~reset;
    assign dbg_gnt    = dbg_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner          <= CORE;
            wait_cnt       <= '0;
            burst_cnt      <= '0;
            dbg_rvalid     <= 1'b0;
            dbg_rdata      <= 64'd0;
            contention_cnt <= 32'd0;
        end else begin
            owner      <= owner_nxt;
            wait_cnt   <= wait_nxt;
            burst_cnt  <= burst_nxt;
            dbg_rvalid <= dbg_grant & ~dbg_we;
            if (dbg_grant && !dbg_we) dbg_rdata <= mem_rdata;
            if (core_req && dbg_req)  contention_cnt <= contention_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected grants/read data are queued as stimulus is driven
// and popped when the DUT responds; a small bench memory stands in for Data_Memory.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we;
    logic [63:0] core_addr, core_wdata;
    logic [2:0]  core_funct3;
    logic [63:0] core_rdata;
    logic        core_stall;
    logic        dbg_req, dbg_we, dbg_lock;
    logic [63:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [63:0] dbg_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] contention_cnt;

    logic [63:0] mem [64];
    logic [31:0] exp_cont;
    bit          exp_q[$];
    logic [63:0] rd_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_WAIT(4), .MAX_BURST(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_funct3(core_funct3),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
        .contention_cnt(contention_cnt)
    );

    assign mem_rdata = mem[mem_addr[8:3]];
    always @(posedge clk) if (mem_write) mem[mem_addr[8:3]] <= mem_wdata;
    always @(posedge clk) begin
        if (reset)                    exp_cont <= 32'd0;
        else if (core_req && dbg_req) exp_cont <= exp_cont + 32'd1;
    end

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        core_req = 0; core_we = 0; dbg_req = 0; dbg_we = 0; dbg_lock = 0;
    endtask

    task automatic test_reset();
        core_req = 1; dbg_req = 1; dbg_we = 1; dbg_lock = 1;
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0 || core_stall !== 1'b0 || dbg_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: wr %b rd %b stall %b gnt %b, want all 0", mem_write, mem_read, core_stall, dbg_gnt);
        end
        next_cycle();
        reset = 0; idle_inputs();
        @(negedge clk);
        checks++;
        if (dbg_rvalid !== 1'b0 || dbg_rdata !== 64'd0 || contention_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: rvalid %b rdata %h cont %0d, want 0", dbg_rvalid, dbg_rdata, contention_cnt);
        end
        next_cycle();
    endtask

    task automatic test_core_only();
        core_req = 1; core_we = 0; core_addr = 64'h10; core_funct3 = 3'b011;
        @(negedge clk);
        checks++;
        if (core_rdata !== 64'hDEAD || core_stall !== 1'b0 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL core_load: rdata %h stall %b rd %b wr %b, want DEAD 0 1 0", core_rdata, core_stall, mem_read, mem_write);
        end
        next_cycle();
        core_we = 1; core_addr = 64'h18; core_wdata = 64'hFEED_FACE_0000_0018; core_funct3 = 3'b010;
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1 || mem_addr !== 64'h18 || mem_funct3 !== 3'b010 || core_stall !== 1'b0) begin
            errors++;
            $display("FAIL core_store: wr %b addr %h f3 %b stall %b", mem_write, mem_addr, mem_funct3, core_stall);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (contention_cnt !== 32'd0) begin
            errors++;
            $display("FAIL core_contention: got %0d want 0", contention_cnt);
        end
        next_cycle();
    endtask

    task automatic test_dbg_read();
        logic [63:0] e;
        dbg_req = 1; dbg_we = 0; dbg_lock = 0; dbg_addr = 64'h20;
        @(negedge clk);
        checks++;
        if (dbg_gnt !== 1'b1 || mem_funct3 !== 3'b011 || mem_read !== 1'b1 || mem_addr !== 64'h20) begin
            errors++;
            $display("FAIL dbg_read_gnt: gnt %b f3 %b rd %b addr %h", dbg_gnt, mem_funct3, mem_read, mem_addr);
        end
        rd_q.push_back(64'h1234_5678_9ABC_DEF0);
        next_cycle();
        dbg_addr = 64'h18;
        rd_q.push_back(64'hFEED_FACE_0000_0018);
        @(negedge clk);
        e = rd_q.pop_front();
        checks++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== e) begin
            errors++;
            $display("FAIL dbg_read_data: rvalid %b rdata %h want 1 %h", dbg_rvalid, dbg_rdata, e);
        end
        next_cycle();
        dbg_req = 0;
        @(negedge clk);
        e = rd_q.pop_front();
        checks++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== e) begin
            errors++;
            $display("FAIL dbg_read_core_store: rvalid %b rdata %h want 1 %h", dbg_rvalid, dbg_rdata, e);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (dbg_rvalid !== 1'b0 || dbg_rdata !== e) begin
            errors++;
            $display("FAIL dbg_rdata_hold: rvalid %b rdata %h want 0 %h", dbg_rvalid, dbg_rdata, e);
        end
        next_cycle();
    endtask

    // Covers the simultaneous first request too: cycle 0 must go to the core.
    task automatic test_contention();
        bit e;
        bit prev = 0;
        logic [63:0] d;
        for (int i = 0; i < 10; i++) exp_q.push_back(i % 5 == 4);
        core_req = 1; core_we = 0; core_addr = 64'h10;
        dbg_req = 1; dbg_we = 0; dbg_lock = 0; dbg_addr = 64'h20;
        for (int c = 0; c < 11; c++) begin
            if (c == 10) idle_inputs();
            @(negedge clk);
            checks++;
            if (dbg_rvalid !== prev) begin
                errors++;
                $display("FAIL contention_rvalid cyc %0d: got %b want %b", c, dbg_rvalid, prev);
            end
            if (prev) begin
                d = rd_q.pop_front();
                checks++;
                if (dbg_rdata !== d) begin
                    errors++;
                    $display("FAIL contention_rdata cyc %0d: got %h want %h", c, dbg_rdata, d);
                end
            end
            prev = 0;
            if (c < 10) begin
                e = exp_q.pop_front();
                checks++;
                if (dbg_gnt !== e || core_stall !== e || (!e && core_rdata !== 64'hDEAD)) begin
                    errors++;
                    $display("FAIL contention_gnt cyc %0d: gnt %b stall %b rdata %h want gnt/stall %b", c, dbg_gnt, core_stall, core_rdata, e);
                end
                if (dbg_gnt === 1'b1) begin
                    rd_q.push_back(64'h1234_5678_9ABC_DEF0);
                    prev = 1;
                end
            end
            next_cycle();
        end
        checks++;
        if (contention_cnt !== exp_cont || exp_cont !== 32'd10) begin
            errors++;
            $display("FAIL contention_cnt: got %0d want %0d (10)", contention_cnt, exp_cont);
        end
    endtask

    task automatic test_burst();
        int k = 0;
        int run = 0;
        int max_run = 0;
        bit e;
        for (int i = 0; i < 17; i++) exp_q.push_back(!(i < 4 || i == 12));
        core_req = 1; core_we = 0; core_addr = 64'h10;
        dbg_req = 1; dbg_lock = 1; dbg_we = 1;
        for (int c = 0; c < 17; c++) begin
            dbg_addr  = 64'h100 + 64'(k * 8);
            dbg_wdata = 64'h1000 + 64'(k);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (dbg_gnt !== e || core_stall !== e) begin
                errors++;
                $display("FAIL burst_gnt cyc %0d: gnt %b stall %b want %b", c, dbg_gnt, core_stall, e);
            end
            if (dbg_gnt === 1'b1) begin
                checks++;
                if (mem_write !== 1'b1 || mem_wdata !== dbg_wdata || mem_addr !== dbg_addr || mem_funct3 !== 3'b011) begin
                    errors++;
                    $display("FAIL burst_write cyc %0d: wr %b data %h addr %h f3 %b", c, mem_write, mem_wdata, mem_addr, mem_funct3);
                end
                k++;
            end
            run = (core_stall === 1'b1) ? run + 1 : 0;
            if (run > max_run) max_run = run;
            next_cycle();
            if (k == 12) dbg_req = 0;
        end
        idle_inputs();
        checks++;
        if (k != 12 || max_run > 8 || mem[32] !== 64'h1000 || mem[43] !== 64'h100B) begin
            errors++;
            $display("FAIL burst_summary: writes %0d max_stall_run %0d mem32 %h mem43 %h", k, max_run, mem[32], mem[43]);
        end
        next_cycle();
    endtask

    task automatic test_lock_drop();
        dbg_req = 1; dbg_lock = 1; dbg_we = 1; dbg_addr = 64'h180; dbg_wdata = 64'hA1;
        @(negedge clk);
        checks++;
        if (dbg_gnt !== 1'b1) begin
            errors++;
            $display("FAIL lock_open: gnt %b want 1", dbg_gnt);
        end
        next_cycle();
        dbg_lock = 0; dbg_wdata = 64'hA2;
        next_cycle();
        dbg_lock = 1; core_req = 1; core_we = 0; core_addr = 64'h10;
        @(negedge clk);
        checks++;
        if (dbg_gnt !== 1'b0 || core_stall !== 1'b0 || core_rdata !== 64'hDEAD) begin
            errors++;
            $display("FAIL lock_drop_owner: gnt %b stall %b rdata %h want 0 0 DEAD", dbg_gnt, core_stall, core_rdata);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        dbg_req = 1; dbg_lock = 1; dbg_we = 1; dbg_addr = 64'h1C0; dbg_wdata = 64'hB0;
        next_cycle();
        dbg_we = 0; dbg_addr = 64'h20;
        next_cycle();
        dbg_we = 1; dbg_wdata = 64'hB1; core_req = 1; reset = 1;
        @(negedge clk);
        checks++;
        if (dbg_rvalid !== 1'b1 || mem_write !== 1'b0 || dbg_gnt !== 1'b0 || core_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_burst_cycle: rvalid %b wr %b gnt %b stall %b want 1 0 0 0", dbg_rvalid, mem_write, dbg_gnt, core_stall);
        end
        next_cycle();
        reset = 0; idle_inputs();
        @(negedge clk);
        checks++;
        if (dbg_rvalid !== 1'b0 || contention_cnt !== 32'd0 || mem[56] !== 64'hB0) begin
            errors++;
            $display("FAIL reset_burst_after: rvalid %b cont %0d mem56 %h want 0 0 B0", dbg_rvalid, contention_cnt, mem[56]);
        end
        next_cycle();
        core_req = 1; core_addr = 64'h10; dbg_req = 1; dbg_lock = 1; dbg_we = 1;
        @(negedge clk);
        checks++;
        if (dbg_gnt !== 1'b0 || core_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_burst_owner: gnt %b stall %b want 0 0", dbg_gnt, core_stall);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (contention_cnt !== exp_cont) begin
            errors++;
            $display("FAIL reset_burst_cont: got %0d want %0d", contention_cnt, exp_cont);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
        mem[2] = 64'hDEAD;
        mem[4] = 64'h1234_5678_9ABC_DEF0;
        reset = 1; idle_inputs();
        core_addr = '0; core_wdata = '0; core_funct3 = 3'b011;
        dbg_addr = '0; dbg_wdata = '0;
        next_cycle();
        test_reset();
        test_core_only();
        test_dbg_read();
        test_contention();
        test_burst();
        test_lock_drop();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
